// File: rtl/lsu_mmio_hs.sv
// Load/store unit: byte-addressable data RAM plus memory-mapped LED/LCD/HEX/switch registers.
// A valid/ready request produces one response beat after WAIT_CYCLES extra cycles.
//
// state  | meaning
// IDLE   | ready for a request; accept latches it and issues the RAM read
// WAIT   | counting down wait states, request held
// RESP   | one-cycle response strobe; store committed on the edge entering here
module lsu_mmio_hs #(
    parameter int          DMEM_AW     = 12,
    parameter int          N_HEX       = 8,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] IO_BASE     = 32'h0000_7000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_we_i,
    input  logic [31:0]        req_addr_i,
    input  logic [31:0]        req_wdata_i,
    input  logic [1:0]         req_size_i,
    input  logic               req_unsigned_i,
    output logic               rsp_valid_o,
    output logic [31:0]        rsp_rdata_o,
    output logic               rsp_err_o,
    input  logic [31:0]        sw_i,
    output logic [31:0]        io_ledr_o,
    output logic [31:0]        io_ledg_o,
    output logic [31:0]        io_lcd_o,
    output logic [N_HEX*32-1:0] io_hex_o
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q;
    logic                 lat_we, lat_unsigned;
    logic [31:0]          lat_addr, lat_wdata;
    logic [1:0]           lat_size;
    logic [31:0]          ledr_q, ledg_q, lcd_q, sw_s1, sw_s2, io_rd_q, ram_q;
    logic [N_HEX*32-1:0]  hex_q;
    logic [31:0]          mem [2**(DMEM_AW-2)];

    logic                 accept, commit;
    logic                 cur_we, cur_unsigned;
    logic [31:0]          cur_addr, cur_wdata;
    logic [1:0]           cur_size;
    logic                 hit_ram, hit_io, sel_ledr, sel_ledg, sel_lcd, sel_sw, sel_hex;
    logic                 misalign, cur_err;
    logic [9:0]           woff;
    logic [3:0]           be;
    logic [31:0]          wd_rep, mask, raw_io, raw, sh, ext;

    assign accept = (state_q == S_IDLE) && req_valid_i;
    // In IDLE the live inputs are the request; afterwards the latched copy is.
    assign cur_we       = (state_q == S_IDLE) ? req_we_i       : lat_we;
    assign cur_addr     = (state_q == S_IDLE) ? req_addr_i     : lat_addr;
    assign cur_wdata    = (state_q == S_IDLE) ? req_wdata_i    : lat_wdata;
    assign cur_size     = (state_q == S_IDLE) ? req_size_i     : lat_size;
    assign cur_unsigned = (state_q == S_IDLE) ? req_unsigned_i : lat_unsigned;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req_valid_i) state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            S_WAIT: if (cnt_q == 4'd1) state_d = S_RESP;
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign commit = (state_d == S_RESP) && (state_q != S_RESP) && !rst_i;

    always_comb begin
        woff     = cur_addr[11:2];
        hit_ram  = (cur_addr[31:DMEM_AW] == '0);
        hit_io   = (cur_addr[31:12] == IO_BASE[31:12]);
        sel_ledr = hit_io && (woff == 10'd0);
        sel_ledg = hit_io && (woff == 10'd1);
        sel_lcd  = hit_io && (woff == 10'd2);
        sel_sw   = hit_io && (woff == 10'd4);
        sel_hex  = hit_io && (woff >= 10'd8) && (woff < 10'(8 + N_HEX));
        misalign = ((cur_size == 2'b01) && cur_addr[0]) ||
                   ((cur_size == 2'b10) && (cur_addr[1:0] != 2'b00));
        cur_err  = (cur_size == 2'b11) || misalign ||
                   !(hit_ram || sel_ledr || sel_ledg || sel_lcd || sel_sw || sel_hex) ||
                   (cur_we && sel_sw);

        case (cur_size)
            2'b00:   begin be = 4'b0001 << cur_addr[1:0]; wd_rep = {4{cur_wdata[7:0]}}; end
            2'b01:   begin be = cur_addr[1] ? 4'b1100 : 4'b0011; wd_rep = {2{cur_wdata[15:0]}}; end
            default: begin be = 4'b1111; wd_rep = cur_wdata; end
        endcase
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

        raw_io = '0;
        if (sel_ledr) raw_io = ledr_q;
        if (sel_ledg) raw_io = ledg_q;
        if (sel_lcd)  raw_io = lcd_q;
        if (sel_sw)   raw_io = sw_s2;
        for (int i = 0; i < N_HEX; i++)
            if (hit_io && (woff == 10'(8 + i))) raw_io = hex_q[32*i +: 32];

        raw = hit_ram ? ram_q : io_rd_q;
        sh  = raw >> {cur_addr[1:0], 3'b000};
        case (cur_size)
            2'b00:   ext = cur_unsigned ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   ext = cur_unsigned ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: ext = raw;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            lat_we       <= 1'b0;
            lat_unsigned <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_size     <= '0;
            ledr_q       <= '0;
            ledg_q       <= '0;
            lcd_q        <= '0;
            hex_q        <= '0;
            sw_s1        <= '0;
            sw_s2        <= '0;
            io_rd_q      <= '0;
        end else begin
            state_q <= state_d;
            sw_s1   <= sw_i;
            sw_s2   <= sw_s1;
            if (accept) begin
                lat_we       <= req_we_i;
                lat_unsigned <= req_unsigned_i;
                lat_addr     <= req_addr_i;
                lat_wdata    <= req_wdata_i;
                lat_size     <= req_size_i;
                cnt_q        <= 4'(WAIT_CYCLES);
            end else if (state_q == S_WAIT) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (commit) begin
                io_rd_q <= raw_io;
                if (cur_we && !cur_err) begin
                    if (sel_ledr) ledr_q <= (ledr_q & ~mask) | (wd_rep & mask);
                    if (sel_ledg) ledg_q <= (ledg_q & ~mask) | (wd_rep & mask);
                    if (sel_lcd)  lcd_q  <= (lcd_q  & ~mask) | (wd_rep & mask);
                    for (int i = 0; i < N_HEX; i++)
                        if (hit_io && (woff == 10'(8 + i)))
                            hex_q[32*i +: 32] <= (hex_q[32*i +: 32] & ~mask) | (wd_rep & mask);
                end
            end
        end
    end

    // RAM contents survive reset; commit already excludes a reset edge.
    always_ff @(posedge clk_i) begin
        if (accept) ram_q <= mem[req_addr_i[DMEM_AW-1:2]];
        if (commit && cur_we && !cur_err && hit_ram)
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[cur_addr[DMEM_AW-1:2]][8*b +: 8] <= wd_rep[8*b +: 8];
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign rsp_valid_o = (state_q == S_RESP);
    assign rsp_err_o   = (state_q == S_RESP) && cur_err;
    assign rsp_rdata_o = ((state_q == S_RESP) && !cur_err && !cur_we) ? ext : 32'h0;
    assign io_ledr_o   = ledr_q;
    assign io_ledg_o   = ledg_q;
    assign io_lcd_o    = lcd_q;
    assign io_hex_o    = hex_q;

endmodule

// File: tb/tb_lsu_mmio_hs.sv
// Bench for lsu_mmio_hs: one instance with no wait states, one with three,
// both checked against a byte-level memory/register model.
module tb_lsu_mmio_hs;

    localparam logic [31:0] IOB = 32'h0000_7000;

    logic        clk = 1'b0;
    logic        rst [2];
    logic        vld [2], we [2], uns [2];
    logic [31:0] addr [2], wdat [2], sw [2];
    logic [1:0]  sz [2];
    logic        rdy [2], rv [2], err [2];
    logic [31:0] rd [2], ledr [2], ledg [2], lcd [2];
    logic [255:0] hex [2];

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0]  mem_m [int];
    logic [31:0] regs_m [2][12];

    always #5 clk = ~clk;

    lsu_mmio_hs #(.WAIT_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_i(rst[0]), .req_valid_i(vld[0]), .req_ready_o(rdy[0]),
        .req_we_i(we[0]), .req_addr_i(addr[0]), .req_wdata_i(wdat[0]), .req_size_i(sz[0]),
        .req_unsigned_i(uns[0]), .rsp_valid_o(rv[0]), .rsp_rdata_o(rd[0]), .rsp_err_o(err[0]),
        .sw_i(sw[0]), .io_ledr_o(ledr[0]), .io_ledg_o(ledg[0]), .io_lcd_o(lcd[0]), .io_hex_o(hex[0]));

    lsu_mmio_hs #(.WAIT_CYCLES(3)) dut1 (
        .clk_i(clk), .rst_i(rst[1]), .req_valid_i(vld[1]), .req_ready_o(rdy[1]),
        .req_we_i(we[1]), .req_addr_i(addr[1]), .req_wdata_i(wdat[1]), .req_size_i(sz[1]),
        .req_unsigned_i(uns[1]), .rsp_valid_o(rv[1]), .rsp_rdata_o(rd[1]), .rsp_err_o(err[1]),
        .sw_i(sw[1]), .io_ledr_o(ledr[1]), .io_ledg_o(ledg[1]), .io_lcd_o(lcd[1]), .io_hex_o(hex[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_io(input int d, input string tag);
        chk({tag, " ledr"}, ledr[d], regs_m[d][0]);
        chk({tag, " ledg"}, ledg[d], regs_m[d][1]);
        chk({tag, " lcd"},  lcd[d],  regs_m[d][2]);
        for (int i = 0; i < 8; i++)
            chk({tag, " hex"}, hex[d][32*i +: 32], regs_m[d][4+i]);
    endtask

    // Reference: byte-by-byte little-endian access on a flat address map.
    task automatic model(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] s, input bit u,
                         output logic [31:0] er, output bit ee);
        int nb, r, off;
        bit in_ram, in_io;
        logic [31:0] val;
        logic [7:0] b;
        nb = 1 << s;
        er = 0;
        ee = 0;
        in_ram = (a < 32'd4096);
        in_io  = (a >= IOB) && (a < IOB + 32'd4096);
        off = int'(a - IOB);
        r = -1;
        if (in_io) begin
            case (off & ~3)
                0:  r = 0;
                4:  r = 1;
                8:  r = 2;
                16: r = 3;
                default: if ((off & ~3) >= 32 && (off & ~3) < 64) r = 4 + ((off & ~3) - 32) / 4;
            endcase
        end
        if (s == 2'b11) ee = 1;
        else if (a % nb != 0) ee = 1;
        if (!in_ram && r < 0) ee = 1;
        if (w && r == 3) ee = 1;
        if (ee) return;
        if (w) begin
            for (int k = 0; k < nb; k++) begin
                b = wd[8*k +: 8];
                if (in_ram) mem_m[d*65536 + int'(a) + k] = b;
                else regs_m[d][r][8*((off % 4) + k) +: 8] = b;
            end
        end else begin
            val = 0;
            for (int k = 0; k < nb; k++) begin
                if (in_ram) b = mem_m[d*65536 + int'(a) + k];
                else if (r == 3) b = sw[d][8*((off % 4) + k) +: 8];
                else b = regs_m[d][r][8*((off % 4) + k) +: 8];
                val = val | (32'(b) << (8*k));
            end
            if (nb < 4 && !u && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8*nb));
            er = val;
        end
    endtask

    task automatic txn(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] s, input bit u, input bit junk);
        logic [31:0] er;
        bit ee;
        int n;
        @(negedge clk);
        vld[d] = 1; we[d] = w; addr[d] = a; wdat[d] = wd; sz[d] = s; uns[d] = u;
        n = 0;
        while (!rdy[d] && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        if (junk) begin
            we[d] = 1; addr[d] = IOB + 32'h4; wdat[d] = 32'h22; sz[d] = 2'b10;
        end else vld[d] = 0;
        n = 1;
        while (!rv[d] && n < 40) begin
            chk("ready during wait", rdy[d], 0);
            check_io(d, "pre-commit");
            @(posedge clk); #1;
            n++;
        end
        vld[d] = 0;
        model(d, w, a, wd, s, u, er, ee);
        chk("latency", n, (d == 0) ? 1 : 4);
        chk("rdata", rd[d], er);
        chk("err", err[d], ee);
        check_io(d, "post-commit");
        @(posedge clk); #1;
        chk("valid one beat", rv[d], 0);
        chk("ready after resp", rdy[d], 1);
    endtask

    task automatic set_sw(input int d, input logic [31:0] v);
        @(negedge clk);
        sw[d] = v;
        repeat (3) @(posedge clk);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 3))
            0, 1: a = 32'($urandom_range(0, 63));
            2: begin
                case ($urandom_range(0, 4))
                    0: a = IOB;
                    1: a = IOB + 32'h4;
                    2: a = IOB + 32'h8;
                    3: a = IOB + 32'h10;
                    default: a = IOB + 32'h20 + 32'(4 * $urandom_range(0, 7));
                endcase
                a = a + 32'($urandom_range(0, 3));
            end
            default: begin
                case ($urandom_range(0, 3))
                    0: a = 32'h0000_2000;
                    1: a = IOB + 32'h14;
                    2: a = IOB + 32'h40;
                    default: a = 32'h8000_0010;
                endcase
            end
        endcase
        return a;
    endfunction

    initial begin
        logic [31:0] a;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1; vld[d] = 0; we[d] = 0; uns[d] = 0;
            addr[d] = 0; wdat[d] = 0; sz[d] = 0; sw[d] = 0;
            for (int r = 0; r < 12; r++) regs_m[d][r] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst[0] = 0; rst[1] = 0;
        for (int d = 0; d < 2; d++) begin
            chk("reset ready", rdy[d], 1);
            chk("reset valid", rv[d], 0);
            chk("reset rdata", rd[d], 0);
            chk("reset err", err[d], 0);
            check_io(d, "reset");
        end

        // Reset during wait aborts a LEDR store on the 3-wait-state unit.
        @(negedge clk);
        vld[1] = 1; we[1] = 1; addr[1] = IOB; wdat[1] = 32'h1; sz[1] = 2'b10;
        @(posedge clk); #1;
        vld[1] = 0;
        chk("abort ready low", rdy[1], 0);
        @(negedge clk);
        rst[1] = 1;
        @(posedge clk); #1;
        chk("abort valid", rv[1], 0);
        chk("abort ready", rdy[1], 1);
        @(negedge clk);
        rst[1] = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("abort no rsp", rv[1], 0);
            chk("abort ledr", ledr[1], 0);
        end
        chk("abort ready after", rdy[1], 1);

        for (int d = 0; d < 2; d++) begin
            txn(d, 1, 32'h100, 32'hDEAD_BEEF, 2'b10, 0, 0);
            txn(d, 0, 32'h100, 0, 2'b10, 0, 0);
            txn(d, 1, 32'h100, 32'h1122_3344, 2'b10, 0, 0);
            txn(d, 1, 32'h103, 32'h0000_0080, 2'b00, 0, 0);
            txn(d, 0, 32'h100, 0, 2'b10, 0, 0);
            txn(d, 0, 32'h103, 0, 2'b00, 0, 0);
            txn(d, 0, 32'h103, 0, 2'b00, 1, 0);
            txn(d, 0, 32'h101, 0, 2'b01, 0, 0);
            txn(d, 0, 32'h100, 0, 2'b10, 0, 0);
            txn(d, 0, 32'h102, 0, 2'b01, 0, 0);
            txn(d, 1, 32'h104, 32'h0000_ABCD, 2'b11, 0, 0);
            txn(d, 1, IOB + 32'h10, 32'h5, 2'b10, 0, 0);
            txn(d, 0, IOB + 32'h0C, 0, 2'b10, 0, 0);
            txn(d, 0, 32'h8000_0100, 0, 2'b10, 0, 0);
            txn(d, 1, IOB + 32'h2C, 32'h0000_007F, 2'b10, 0, 0);
            txn(d, 1, IOB + 32'h6, 32'hBEEF_8001, 2'b01, 0, 0);
            txn(d, 0, IOB + 32'h6, 0, 2'b01, 0, 0);
            set_sw(d, 32'h0000_00A5);
            txn(d, 0, IOB + 32'h10, 0, 2'b10, 0, 0);
        end
        // A second request held during the wait must not be taken.
        txn(1, 1, IOB + 32'h8, 32'h0000_0011, 2'b10, 0, 1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("held request ignored", ledg[1], regs_m[1][1]);
        end

        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 64; w += 4) txn(d, 1, 32'(w), $urandom, 2'b10, 0, 0);
        for (int i = 0; i < 120; i++) begin
            int d;
            d = i % 2;
            if (i % 16 == 0) set_sw(d, $urandom);
            a = rand_addr();
            txn(d, 1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
